// File: rtl/posit_mult_sched_pkg.sv
// posit_mult_sched_pkg: shared defaults, posit special encodings and tag width derivation
package posit_mult_sched_pkg;
  localparam int N_DEF = 16;
  localparam int ES_DEF = 3;
  localparam int NREQ_DEF = 4;
  localparam logic [N_DEF-1:0] NAR_DEF = 1 << (N_DEF - 1);
  localparam logic [N_DEF-1:0] ZERO_DEF = '0;
  function automatic int tag_w(input int nreq);
    return $clog2(nreq);
  endfunction
endpackage

// File: rtl/posit_mult_sched_if.sv
// posit_mult_sched_if: requester, multiplier and response buses of the scheduler
interface posit_mult_sched_if
  import posit_mult_sched_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int NREQ = NREQ_DEF
);
  localparam int TAG_W = tag_w(NREQ);
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*N-1:0] req_in1, req_in2;
  logic [N-1:0] mul_in1, mul_in2, mul_result;
  logic mul_start, mul_inf, mul_zero, mul_done;
  logic rsp_valid;
  logic [TAG_W-1:0] rsp_tag;
  logic [N-1:0] rsp_result;
  logic rsp_inf, rsp_zero;
  logic busy, proto_err;
  modport master (
    output req_valid, req_in1, req_in2, mul_result, mul_inf, mul_zero, mul_done,
    input req_ready, mul_in1, mul_in2, mul_start, rsp_valid, rsp_tag, rsp_result, rsp_inf, rsp_zero,
    busy, proto_err
  );
  modport slave (
    input req_valid, req_in1, req_in2, mul_result, mul_inf, mul_zero, mul_done,
    output req_ready, mul_in1, mul_in2, mul_start, rsp_valid, rsp_tag, rsp_result, rsp_inf, rsp_zero,
    busy, proto_err
  );
endinterface

// File: rtl/posit_mult_sched_rr_arbiter.sv
// posit_mult_sched_rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module posit_mult_sched_rr_arbiter
  import posit_mult_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int TAG_W = tag_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [TAG_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [TAG_W-1:0] gnt_idx,
  output logic             any
);
  // Walk from farthest to nearest so the lane closest to ptr wins.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    any = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[(int'(ptr) + j) % NREQ]) begin
        gnt = NREQ'(1) << ((int'(ptr) + j) % NREQ);
        gnt_idx = TAG_W'((int'(ptr) + j) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/posit_mult_sched.sv
// posit_mult_sched: round-robin sharing of one posit multiplier among NREQ requesters,
// with responses tagged by requester index through a LAT+1 deep tag pipe.
module posit_mult_sched
  import posit_mult_sched_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int es = ES_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int LAT = 0,
  localparam int TAG_W = tag_w(NREQ)
) (
  input logic aclk,
  input logic areset,
  posit_mult_sched_if.slave bus
);
  logic [NREQ-1:0] gnt;
  logic [TAG_W-1:0] gnt_idx, ptr;
  logic any, take, done_ok;
  logic [LAT:0] pv;
  logic [TAG_W-1:0] pt [LAT+1];
  if (NREQ < 2 || NREQ > 16 || es < 0 || es > N - 2) begin : g_bad_cfg
    $error("posit_mult_sched: unsupported NREQ or es");
  end
  posit_mult_sched_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(bus.req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any(any)
  );
  assign take = any & ~areset;
  assign bus.req_ready = take ? gnt : '0;
  assign done_ok = bus.mul_done & pv[LAT];
  // pv[0] is the issue stage, so it doubles as the start strobe.
  assign bus.mul_start = pv[0];
  assign bus.busy = |pv;
  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr <= '0;
      pv <= '0;
      bus.mul_in1 <= '0;
      bus.mul_in2 <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_tag <= '0;
      bus.rsp_result <= '0;
      bus.rsp_inf <= 1'b0;
      bus.rsp_zero <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      pv <= (LAT + 1)'({pv, take});
      if (take) begin
        ptr <= gnt_idx == TAG_W'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
        bus.mul_in1 <= bus.req_in1[int'(gnt_idx) * N +: N];
        bus.mul_in2 <= bus.req_in2[int'(gnt_idx) * N +: N];
      end
      bus.rsp_valid <= done_ok;
      if (done_ok) begin
        bus.rsp_tag <= pt[LAT];
        bus.rsp_result <= bus.mul_result;
        bus.rsp_inf <= bus.mul_inf;
        bus.rsp_zero <= bus.mul_zero;
      end
      // Any disagreement between the tail and mul_done is a lost or phantom result.
      bus.proto_err <= bus.proto_err | (bus.mul_done ^ pv[LAT]);
    end
  end
  always_ff @(posedge aclk) begin
    pt[0] <= gnt_idx;
    for (int k = 1; k <= LAT; k++) pt[k] <= pt[k-1];
  end
endmodule

// File: tb/tb_posit_mult_sched.sv
// tb_posit_mult_sched: directed and random checks of three schedulers (LAT 0, 1, 3) sharing stimulus,
// scored against a queue model of grants and due response cycles.
module tb_posit_mult_sched;
  import posit_mult_sched_pkg::*;
  typedef struct {
    int due;
    logic [1:0] tag;
    logic [15:0] res;
    logic drop;
  } ent_t;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;
  logic [15:0] a_op [4];
  logic [15:0] b_op [4];
  logic [3:0] req_valid;
  logic [63:0] in1, in2;
  logic force_done, kill_done;
  logic [3:0] rdy [3];
  logic rv [3], ri [3], rz [3], bz [3], pe_o [3];
  logic [1:0] rt [3];
  logic [15:0] rr [3];
  int n_chk = 0, n_fail = 0, cyc = 0, ptr = 0;
  ent_t q [3][$];
  logic [1:0] lt [3];
  logic [15:0] lr [3];
  logic li [3], lz [3], pe [3];
  logic pe_chk;

  // Stand-in multiplier: exact for special values and 1.0, arbitrary but deterministic otherwise.
  function automatic logic [15:0] pm(input logic [15:0] a, input logic [15:0] b);
    if (a == NAR_DEF || b == NAR_DEF) return NAR_DEF;
    if (a == ZERO_DEF || b == ZERO_DEF) return ZERO_DEF;
    if (a == 16'h4000) return b;
    if (b == 16'h4000) return a;
    return a ^ b ^ 16'h5a5a;
  endfunction
  function automatic int lat(input int g);
    return g == 0 ? 0 : g == 1 ? 1 : 3;
  endfunction
  function automatic logic [15:0] pick();
    int r = $urandom_range(0, 5);
    return r == 0 ? NAR_DEF : r == 1 ? ZERO_DEF : r == 2 ? 16'h4000 : 16'($urandom);
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign in1[i*16 +: 16] = a_op[i];
    assign in2[i*16 +: 16] = b_op[i];
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g == 0 ? 0 : g == 1 ? 1 : 3;
    posit_mult_sched_if #(.N(16), .NREQ(4)) bus ();
    posit_mult_sched #(.N(16), .es(3), .NREQ(4), .LAT(L)) dut (
      .aclk(aclk),
      .areset(areset),
      .bus(bus.slave)
    );
    logic sd;
    logic [15:0] sa, sb;
    if (L == 0) begin : g_comb
      assign sd = bus.mul_start;
      assign sa = bus.mul_in1;
      assign sb = bus.mul_in2;
    end else begin : g_pipe
      logic dv [L];
      logic [15:0] da [L];
      logic [15:0] db [L];
      always_ff @(posedge aclk) begin
        dv[0] <= bus.mul_start;
        da[0] <= bus.mul_in1;
        db[0] <= bus.mul_in2;
        for (int k = 1; k < L; k++) begin
          dv[k] <= dv[k-1];
          da[k] <= da[k-1];
          db[k] <= db[k-1];
        end
      end
      assign sd = dv[L-1];
      assign sa = da[L-1];
      assign sb = db[L-1];
    end
    assign bus.req_valid = req_valid;
    assign bus.req_in1 = in1;
    assign bus.req_in2 = in2;
    assign bus.mul_done = (sd & ~kill_done) | force_done;
    assign bus.mul_result = pm(sa, sb);
    assign bus.mul_inf = bus.mul_result == NAR_DEF;
    assign bus.mul_zero = bus.mul_result == ZERO_DEF;
    assign rdy[g] = bus.req_ready;
    assign rv[g] = bus.rsp_valid;
    assign rt[g] = bus.rsp_tag;
    assign rr[g] = bus.rsp_result;
    assign ri[g] = bus.rsp_inf;
    assign rz[g] = bus.rsp_zero;
    assign bz[g] = bus.busy;
    assign pe_o[g] = bus.proto_err;
  end

  task automatic chk(input string name, input int g, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat=%0d: observed %h expected %h", name, lat(g), obs, exp);
    end
  endtask

  // One clock: check the combinational grant, advance the model, then check registered outputs.
  task automatic step();
    logic [3:0] er;
    int gi;
    ent_t e;
    logic ev;
    #1;
    gi = -1;
    if (!areset)
      for (int j = 0; j < 4; j++)
        if (gi < 0 && req_valid[(ptr + j) % 4]) gi = (ptr + j) % 4;
    er = gi < 0 ? 4'b0 : 4'(1 << gi);
    for (int g = 0; g < 3; g++) begin
      chk("req_ready", g, 32'(rdy[g]), 32'(er));
      if (gi >= 0) q[g].push_back('{cyc + lat(g) + 2, 2'(gi), pm(a_op[gi], b_op[gi]), kill_done});
    end
    if (gi >= 0) ptr = (gi + 1) % 4;
    @(posedge aclk);
    #1;
    cyc++;
    for (int g = 0; g < 3; g++) begin
      ev = 1'b0;
      if (areset) begin
        q[g].delete();
        lt[g] = '0;
        lr[g] = '0;
        li[g] = 1'b0;
        lz[g] = 1'b0;
        pe[g] = 1'b0;
      end else begin
        if (force_done) pe[g] = 1'b1;
        if (q[g].size() > 0 && q[g][0].due == cyc) begin
          e = q[g].pop_front();
          if (e.drop) pe[g] = 1'b1;
          else begin
            ev = 1'b1;
            lt[g] = e.tag;
            lr[g] = e.res;
            li[g] = e.res == NAR_DEF;
            lz[g] = e.res == ZERO_DEF;
          end
        end
      end
      chk("rsp", g, 32'({rv[g], rt[g], rr[g], ri[g], rz[g]}), 32'({ev, lt[g], lr[g], li[g], lz[g]}));
      chk("busy", g, 32'(bz[g]), 32'(q[g].size() != 0));
      if (pe_chk) chk("proto_err", g, 32'(pe_o[g]), 32'(pe[g]));
    end
    if (areset) ptr = 0;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) step();
  endtask

  task automatic pulse_reset();
    areset = 1'b1;
    step();
    areset = 1'b0;
  endtask

  initial begin
    pe_chk = 1'b1;
    force_done = 1'b0;
    kill_done = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    repeat (5) step();
    areset = 1'b0;
    chk("reset mul_start", 2, 32'(g_dut[2].bus.mul_start), 32'(0));
    chk("reset mul_in1", 2, 32'(g_dut[2].bus.mul_in1), 32'(0));
    // single op on lane 1: 1.0 x 1.0
    a_op[1] = 16'h4000;
    b_op[1] = 16'h4000;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    chk("issue mul_start", 0, 32'(g_dut[0].bus.mul_start), 32'(1));
    chk("issue mul_in1", 0, 32'(g_dut[0].bus.mul_in1), 32'h4000);
    idle(6);
    // saturation from ptr 0
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      a_op[i] = pick();
      b_op[i] = pick();
    end
    req_valid = 4'hf;
    repeat (8) step();
    idle(6);
    // special values on lane 2, leaving ptr at 3
    a_op[2] = 16'h8000;
    b_op[2] = 16'h4000;
    req_valid = 4'b0100;
    step();
    idle(5);
    a_op[2] = 16'h0000;
    req_valid = 4'b0100;
    step();
    idle(5);
    // fairness between lanes 0 and 3
    req_valid = 4'b1001;
    repeat (4) step();
    idle(6);
    // random traffic
    repeat (300) begin
      for (int i = 0; i < 4; i++) begin
        a_op[i] = pick();
        b_op[i] = pick();
      end
      req_valid = 4'($urandom_range(0, 15));
      step();
    end
    idle(6);
    // phantom mul_done while idle
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    idle(4);
    pulse_reset();
    // issued op whose mul_done never comes
    kill_done = 1'b1;
    req_valid = 4'b0001;
    step();
    idle(6);
    kill_done = 1'b0;
    pulse_reset();
    idle(2);
    // reset with ops in flight
    req_valid = 4'b0111;
    repeat (2) step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    pe_chk = 1'b0;
    idle(6);
    pe_chk = 1'b1;
    pulse_reset();
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
